// File: rtl/regfile_sequencer.sv
// picoMIPS three-phase sequencer (decode/execute/writeback) with an 8x8 register
// file, two combinational read ports and switch/LED mapping into the address space.
module regfile_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] reg1_addr,
  input  logic [2:0] reg2_addr,
  input  logic [7:0] wr_data,
  input  logic [8:0] switches,
  output logic [1:0] cycle,
  output logic       we,
  output logic [7:0] reg_1,
  output logic [7:0] reg_2,
  output logic [7:0] leds
);

  typedef enum logic [1:0] {
    PH_DECODE    = 2'b00,
    PH_EXECUTE   = 2'b01,
    PH_WRITEBACK = 2'b10,
    PH_ILLEGAL   = 2'b11
  } phase_t;

  localparam logic [2:0] ADDR_SW07 = 3'd5;
  localparam logic [2:0] ADDR_SW8  = 3'd6;
  localparam logic [2:0] ADDR_LED  = 3'd7;

  phase_t     phase_q;
  phase_t     phase_d;
  logic [7:0] regs_q [8];

  // Switch addresses always return live switch state; their backing storage is shadowed.
  function automatic logic [7:0] read_port(input logic [2:0] addr,
                                           input logic [8:0] sw,
                                           input logic [7:0] stored);
    logic [7:0] val;
    case (addr)
      ADDR_SW07: val = sw[7:0];
      ADDR_SW8:  val = {7'b0, sw[8]};
      default:   val = stored;
    endcase
    return val;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) phase_q <= PH_DECODE;
    else       phase_q <= phase_d;
  end

  always_comb begin
    phase_d = PH_DECODE;
    case (phase_q)
      PH_DECODE:  phase_d = PH_EXECUTE;
      PH_EXECUTE: phase_d = PH_WRITEBACK;
      default:    phase_d = PH_DECODE;
    endcase
  end

  assign cycle = phase_q;
  assign we    = phase_q[0];

  // Single write port: the write lands on the edge that ends execute, no bypass to reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[reg2_addr] <= wr_data;
    end
  end

  assign reg_1 = read_port(reg1_addr, switches, regs_q[reg1_addr]);
  assign reg_2 = read_port(reg2_addr, switches, regs_q[reg2_addr]);
  assign leds  = regs_q[ADDR_LED];

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer: a reference register model feeds a queue of
// expected observations that are popped and compared when each phase is reached.
module tb_regfile_sequencer;

  logic       clk;
  logic       reset;
  logic [2:0] reg1_addr;
  logic [2:0] reg2_addr;
  logic [7:0] wr_data;
  logic [8:0] switches;
  logic [1:0] cycle;
  logic       we;
  logic [7:0] reg_1;
  logic [7:0] reg_2;
  logic [7:0] leds;

  regfile_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .reg1_addr (reg1_addr),
    .reg2_addr (reg2_addr),
    .wr_data   (wr_data),
    .switches  (switches),
    .cycle     (cycle),
    .we        (we),
    .reg_1     (reg_1),
    .reg_2     (reg_2),
    .leds      (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int SEL_CYCLE = 0;
  localparam int SEL_WE    = 1;
  localparam int SEL_REG1  = 2;
  localparam int SEL_REG2  = 3;
  localparam int SEL_LEDS  = 4;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] exp;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model [8];
  int         checks;
  int         failures;

  function automatic logic [7:0] observe(input int sel);
    case (sel)
      SEL_CYCLE: return {6'b0, cycle};
      SEL_WE:    return {7'b0, we};
      SEL_REG1:  return reg_1;
      SEL_REG2:  return reg_2;
      default:   return leds;
    endcase
  endfunction

  function automatic logic [7:0] model_read(input logic [2:0] addr);
    if (addr == 3'd5) return switches[7:0];
    if (addr == 3'd6) return {7'b0, switches[8]};
    return model[addr];
  endfunction

  task automatic push(input string tag, input int sel, input logic [7:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t       e;
    logic [7:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
  endtask

  // One full instruction starting and ending at a decode-phase negedge.
  task automatic run_instr(input string tag, input logic [2:0] a1, input logic [2:0] a2,
                           input logic [7:0] wd, input logic [8:0] sw);
    reg1_addr = a1;
    reg2_addr = a2;
    wr_data   = wd;
    switches  = sw;
    #1;
    push({tag, ".dec_cycle"}, SEL_CYCLE, 8'h00);
    push({tag, ".dec_we"}, SEL_WE, 8'h00);
    drain();
    step();
    push({tag, ".exe_cycle"}, SEL_CYCLE, 8'h01);
    push({tag, ".exe_we"}, SEL_WE, 8'h01);
    push({tag, ".exe_reg1"}, SEL_REG1, model_read(a1));
    push({tag, ".exe_reg2"}, SEL_REG2, model_read(a2));
    drain();
    step();
    model[a2] = wd;
    push({tag, ".wb_cycle"}, SEL_CYCLE, 8'h02);
    push({tag, ".wb_we"}, SEL_WE, 8'h00);
    push({tag, ".wb_reg1"}, SEL_REG1, model_read(a1));
    push({tag, ".wb_reg2"}, SEL_REG2, model_read(a2));
    push({tag, ".wb_leds"}, SEL_LEDS, model[7]);
    drain();
    step();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    reg1_addr = 3'd0;
    reg2_addr = 3'd0;
    wr_data   = 8'h00;
    switches  = 9'h000;
    model_clear();
    repeat (2) @(negedge clk);

    reg1_addr = 3'd1;
    reg2_addr = 3'd7;
    #1;
    push("rst.cycle", SEL_CYCLE, 8'h00);
    push("rst.we", SEL_WE, 8'h00);
    push("rst.leds", SEL_LEDS, 8'h00);
    push("rst.reg1", SEL_REG1, 8'h00);
    push("rst.reg2", SEL_REG2, 8'h00);
    drain();
    reset = 1'b0;

    // Preload R1/R2, then the main read/write instruction and a readback.
    run_instr("ld_r1", 3'd0, 3'd1, 8'h3C, 9'h000);
    run_instr("ld_r2", 3'd0, 3'd2, 8'hA5, 9'h000);
    run_instr("rw12", 3'd1, 3'd2, 8'h7E, 9'h000);
    run_instr("rb12", 3'd1, 3'd2, 8'h7E, 9'h000);

    run_instr("sw07", 3'd5, 3'd4, 8'h12, 9'h15A);
    run_instr("sw8_hi", 3'd6, 3'd4, 8'h34, 9'h100);
    run_instr("sw8_lo", 3'd6, 3'd1, 8'h3C, 9'h0FF);
    run_instr("wr_sw07", 3'd4, 3'd5, 8'hEE, 9'h0A3);
    run_instr("rd_sw07", 3'd5, 3'd5, 8'h99, 9'h1C4);
    run_instr("wr_z", 3'd0, 3'd0, 8'h11, 9'h000);
    run_instr("rd_z", 3'd0, 3'd0, 8'h00, 9'h000);
    run_instr("led", 3'd0, 3'd7, 8'hC3, 9'h000);
    run_instr("wr_r3", 3'd7, 3'd3, 8'h55, 9'h000);

    // Reset during execute must abort the pending write to R3.
    reg1_addr = 3'd3;
    reg2_addr = 3'd3;
    wr_data   = 8'hEE;
    switches  = 9'h000;
    step();
    #1;
    push("abort.exe_cycle", SEL_CYCLE, 8'h01);
    push("abort.exe_reg1", SEL_REG1, 8'h55);
    drain();
    reset = 1'b1;
    step();
    model_clear();
    push("abort.cycle", SEL_CYCLE, 8'h00);
    push("abort.we", SEL_WE, 8'h00);
    push("abort.r3", SEL_REG1, 8'h00);
    push("abort.r3_p2", SEL_REG2, 8'h00);
    push("abort.leds", SEL_LEDS, 8'h00);
    drain();
    reset = 1'b0;
    run_instr("post_rst", 3'd3, 3'd5, 8'h66, 9'h02B);
    run_instr("post_rst2", 3'd7, 3'd3, 8'h01, 9'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
